// File: rtl/posit_extract_accum_pipe_if.sv
// +----------------------------------------------------------------------------+
// | posit_extract_accum_pipe_if                                                |
// | Valid/ready stream bundle between a posit source, the extractor and sink.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface posit_extract_accum_pipe_if #(
  parameter int NBITS   = 32,
  parameter int SCALE_W = 8,
  parameter int FRAC_W  = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [NBITS-1:0]   in_posit;
  logic               out_valid;
  logic               out_ready;
  logic               out_sign;
  logic               out_zero;
  logic               out_inf;
  logic [SCALE_W-1:0] out_scale;
  logic [FRAC_W-1:0]  out_frac;
  logic [NBITS-2:0]   out_abs;

  modport master (
    output in_valid, in_posit, out_ready,
    input  in_ready, out_valid, out_sign, out_zero, out_inf, out_scale, out_frac, out_abs
  );

  modport slave (
    input  in_valid, in_posit, out_ready,
    output in_ready, out_valid, out_sign, out_zero, out_inf, out_scale, out_frac, out_abs
  );
endinterface

`default_nettype wire

// File: rtl/posit_extract_accum_pipe.sv
// +----------------------------------------------------------------------------+
// | posit_extract_accum_pipe                                                   |
// | Two-stage posit decoder: sign/zero/NaR/magnitude, then regime/exp/frac.    |
// | Optional: POSIT_EXTRACT_STATS_EN adds saturating zero/NaR output counters. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module posit_extract_accum_pipe #(
  parameter int NBITS   = 32,
  parameter int ES      = 2,
  parameter int SCALE_W = 8,
  parameter int FRAC_W  = 32
) (
  input  wire logic                  clk,
  input  wire logic                  reset,
  posit_extract_accum_pipe_if.slave  bus
`ifdef POSIT_EXTRACT_STATS_EN
  ,
  output logic [31:0]                stat_zero_cnt,
  output logic [31:0]                stat_inf_cnt
`endif
);

  localparam int RUN_W  = $clog2(NBITS) + 1;
  localparam int EF_W   = ES + FRAC_W;
  localparam int WIDE_W = NBITS - 1 + EF_W;

  logic               s1_valid_q, s1_valid_d;
  logic               s1_sign_q,  s1_sign_d;
  logic               s1_zero_q,  s1_zero_d;
  logic               s1_inf_q,   s1_inf_d;
  logic [NBITS-2:0]   s1_abs_q,   s1_abs_d;

  logic               out_valid_q, out_valid_d;
  logic               out_sign_q,  out_sign_d;
  logic               out_zero_q,  out_zero_d;
  logic               out_inf_q,   out_inf_d;
  logic [SCALE_W-1:0] out_scale_q, out_scale_d;
  logic [FRAC_W-1:0]  out_frac_q,  out_frac_d;
  logic [NBITS-2:0]   out_abs_q,   out_abs_d;

  logic               s1_adv;
  logic               in_ready;
  logic [NBITS-1:0]   in_neg;

  logic               dec_r0;
  logic               dec_stop;
  logic [RUN_W-1:0]   dec_run;
  logic [RUN_W-1:0]   dec_rw;
  logic [NBITS-2:0]   dec_rem;
  logic [WIDE_W-1:0]  dec_wide;
  logic [EF_W-1:0]    dec_ef;
  logic [SCALE_W-1:0] dec_k;
  logic [SCALE_W-1:0] dec_exp;
  logic [SCALE_W-1:0] dec_scale;
  logic [FRAC_W-1:0]  dec_frac;

  assign s1_adv   = !out_valid_q || bus.out_ready;
  assign in_ready = !s1_valid_q || s1_adv;
  assign in_neg   = -bus.in_posit;

  // Stage 1: classify and take magnitude of the accepted posit.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_zero_d  = s1_zero_q;
    s1_inf_d   = s1_inf_q;
    s1_abs_d   = s1_abs_q;
    if (in_ready) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_sign_d = bus.in_posit[NBITS-1];
        s1_zero_d = (bus.in_posit == '0);
        s1_inf_d  = (bus.in_posit == {1'b1, {(NBITS-1){1'b0}}});
        s1_abs_d  = bus.in_posit[NBITS-1] ? in_neg[NBITS-2:0] : bus.in_posit[NBITS-2:0];
      end
    end
  end

  // Regime run-length; a regime with no terminator shifts everything out, so
  // exponent and fraction fall naturally to zero.
  always_comb begin
    dec_r0   = s1_abs_q[NBITS-2];
    dec_run  = '0;
    dec_stop = 1'b0;
    for (int i = NBITS - 2; i >= 0; i--) begin
      if (!dec_stop && (s1_abs_q[i] == dec_r0)) begin
        dec_run = dec_run + RUN_W'(1);
      end else begin
        dec_stop = 1'b1;
      end
    end
    dec_rw    = dec_run + RUN_W'(1);
    dec_rem   = s1_abs_q << dec_rw;
    dec_wide  = {dec_rem, {EF_W{1'b0}}};
    dec_ef    = dec_wide[WIDE_W-1 -: EF_W];
    dec_exp   = SCALE_W'(dec_ef >> FRAC_W);
    dec_k     = dec_r0 ? (SCALE_W'(dec_run) - SCALE_W'(1)) : (SCALE_W'(0) - SCALE_W'(dec_run));
    dec_scale = (dec_k << ES) + dec_exp;
    dec_frac  = dec_ef[FRAC_W-1:0];
    if (s1_zero_q || s1_inf_q) begin
      dec_scale = '0;
      dec_frac  = '0;
    end
  end

  // Stage 2: output register only moves when the sink is free or consuming.
  always_comb begin
    out_valid_d = out_valid_q;
    out_sign_d  = out_sign_q;
    out_zero_d  = out_zero_q;
    out_inf_d   = out_inf_q;
    out_scale_d = out_scale_q;
    out_frac_d  = out_frac_q;
    out_abs_d   = out_abs_q;
    if (s1_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_sign_d  = s1_sign_q;
        out_zero_d  = s1_zero_q;
        out_inf_d   = s1_inf_q;
        out_scale_d = dec_scale;
        out_frac_d  = dec_frac;
        out_abs_d   = s1_abs_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_zero_q   <= 1'b0;
      s1_inf_q    <= 1'b0;
      s1_abs_q    <= '0;
      out_valid_q <= 1'b0;
      out_sign_q  <= 1'b0;
      out_zero_q  <= 1'b0;
      out_inf_q   <= 1'b0;
      out_scale_q <= '0;
      out_frac_q  <= '0;
      out_abs_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sign_q   <= s1_sign_d;
      s1_zero_q   <= s1_zero_d;
      s1_inf_q    <= s1_inf_d;
      s1_abs_q    <= s1_abs_d;
      out_valid_q <= out_valid_d;
      out_sign_q  <= out_sign_d;
      out_zero_q  <= out_zero_d;
      out_inf_q   <= out_inf_d;
      out_scale_q <= out_scale_d;
      out_frac_q  <= out_frac_d;
      out_abs_q   <= out_abs_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sign  = out_sign_q;
  assign bus.out_zero  = out_zero_q;
  assign bus.out_inf   = out_inf_q;
  assign bus.out_scale = out_scale_q;
  assign bus.out_frac  = out_frac_q;
  assign bus.out_abs   = out_abs_q;

`ifdef POSIT_EXTRACT_STATS_EN
  logic        out_xfer;
  logic [31:0] zero_cnt_q, zero_cnt_d;
  logic [31:0] inf_cnt_q,  inf_cnt_d;

  assign out_xfer = out_valid_q && bus.out_ready;

  always_comb begin
    zero_cnt_d = zero_cnt_q;
    inf_cnt_d  = inf_cnt_q;
    if (out_xfer && out_zero_q && (zero_cnt_q != '1)) zero_cnt_d = zero_cnt_q + 32'd1;
    if (out_xfer && out_inf_q && (inf_cnt_q != '1))   inf_cnt_d  = inf_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      zero_cnt_q <= '0;
      inf_cnt_q  <= '0;
    end else begin
      zero_cnt_q <= zero_cnt_d;
      inf_cnt_q  <= inf_cnt_d;
    end
  end

  assign stat_zero_cnt = zero_cnt_q;
  assign stat_inf_cnt  = inf_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_posit_extract_accum_pipe.sv
// +----------------------------------------------------------------------------+
// | tb_posit_extract_accum_pipe                                                |
// | Directed bench for the posit extractor (NBITS=32, ES=2, FRAC_W=32).        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_posit_extract_accum_pipe;
  localparam int NBITS   = 32;
  localparam int ES      = 2;
  localparam int SCALE_W = 8;
  localparam int FRAC_W  = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  posit_extract_accum_pipe_if #(.NBITS(NBITS), .SCALE_W(SCALE_W), .FRAC_W(FRAC_W)) bus_if ();

`ifdef POSIT_EXTRACT_STATS_EN
  logic [31:0] stat_zero_cnt;
  logic [31:0] stat_inf_cnt;
`endif

  posit_extract_accum_pipe #(
    .NBITS(NBITS), .ES(ES), .SCALE_W(SCALE_W), .FRAC_W(FRAC_W)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
`ifdef POSIT_EXTRACT_STATS_EN
    ,
    .stat_zero_cnt (stat_zero_cnt),
    .stat_inf_cnt  (stat_inf_cnt)
`endif
  );

  typedef struct {
    logic [31:0] p;
    logic        s;
    logic        z;
    logic        n;
    logic [7:0]  sc;
    logic [31:0] fr;
    logic [30:0] ab;
  } vec_t;

  vec_t vecs [12];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input int idx);
    chk({tag, "_sign"},  bus_if.out_sign,  vecs[idx].s);
    chk({tag, "_zero"},  bus_if.out_zero,  vecs[idx].z);
    chk({tag, "_inf"},   bus_if.out_inf,   vecs[idx].n);
    chk({tag, "_scale"}, bus_if.out_scale, vecs[idx].sc);
    chk({tag, "_frac"},  bus_if.out_frac,  vecs[idx].fr);
    chk({tag, "_abs"},   bus_if.out_abs,   vecs[idx].ab);
  endtask

  task automatic run_vec(input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(posedge clk); #1;
    bus_if.in_valid  = 1'b1;
    bus_if.in_posit  = vecs[idx].p;
    bus_if.out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_accept"}, bus_if.in_ready, 1'b1);
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_lat1"}, bus_if.out_valid, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_lat2"}, bus_if.out_valid, 1'b1);
    check_out(tag, idx);
  endtask

  initial begin
    int          sent;
    int          rcv;
    int          last_cons;
    bit          have_snap;
    bit          acc;
    logic [73:0] snap;
    logic [73:0] now_fields;

    //          posit          s     z     n     scale  frac          abs
    vecs[0]  = '{32'h40000000, 1'b0, 1'b0, 1'b0, 8'h00, 32'h00000000, 31'h40000000};
    vecs[1]  = '{32'h48000000, 1'b0, 1'b0, 1'b0, 8'h01, 32'h00000000, 31'h48000000};
    vecs[2]  = '{32'hC0000000, 1'b1, 1'b0, 1'b0, 8'h00, 32'h00000000, 31'h40000000};
    vecs[3]  = '{32'h00000000, 1'b0, 1'b1, 1'b0, 8'h00, 32'h00000000, 31'h00000000};
    vecs[4]  = '{32'h80000000, 1'b1, 1'b0, 1'b1, 8'h00, 32'h00000000, 31'h00000000};
    vecs[5]  = '{32'h00000001, 1'b0, 1'b0, 1'b0, 8'h88, 32'h00000000, 31'h00000001};
    vecs[6]  = '{32'h7FFFFFFF, 1'b0, 1'b0, 1'b0, 8'h78, 32'h00000000, 31'h7FFFFFFF};
    vecs[7]  = '{32'h4C000000, 1'b0, 1'b0, 1'b0, 8'h01, 32'h80000000, 31'h4C000000};
    vecs[8]  = '{32'hB4000000, 1'b1, 1'b0, 1'b0, 8'h01, 32'h80000000, 31'h4C000000};
    vecs[9]  = '{32'h3C000000, 1'b0, 1'b0, 1'b0, 8'hFF, 32'h80000000, 31'h3C000000};
    vecs[10] = '{32'h08000000, 1'b0, 1'b0, 1'b0, 8'hF4, 32'h00000000, 31'h08000000};
    vecs[11] = '{32'h4A5A5A5A, 1'b0, 1'b0, 1'b0, 8'h01, 32'h4B4B4B40, 31'h4A5A5A5A};

    reset            = 1'b1;
    bus_if.in_valid  = 1'b0;
    bus_if.in_posit  = '0;
    bus_if.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", bus_if.out_valid, 1'b0);
    chk("rst_fields", {bus_if.out_sign, bus_if.out_zero, bus_if.out_inf,
                       bus_if.out_scale, bus_if.out_frac, bus_if.out_abs}, '0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", bus_if.in_ready, 1'b1);
    chk("post_rst_out_valid", bus_if.out_valid, 1'b0);

    for (int i = 0; i < 12; i++) run_vec(i);

    // Streaming: 8 items with a 5-cycle sink stall in cycles 3..7.
    @(posedge clk); #1;
    sent      = 0;
    rcv       = 0;
    last_cons = -1;
    have_snap = 1'b0;
    snap      = '0;
    for (int cyc = 0; cyc < 40 && rcv < 8; cyc++) begin
      bus_if.in_valid  = (sent < 8);
      bus_if.in_posit  = vecs[2 + ((sent < 8) ? sent : 0)].p;
      bus_if.out_ready = !(cyc >= 3 && cyc <= 7);
      @(negedge clk);
      now_fields = {bus_if.out_sign, bus_if.out_zero, bus_if.out_inf,
                    bus_if.out_scale, bus_if.out_frac, bus_if.out_abs};
      if (bus_if.out_valid && !bus_if.out_ready) begin
        if (have_snap) chk($sformatf("stall_stable_c%0d", cyc), now_fields, snap);
        snap      = now_fields;
        have_snap = 1'b1;
        if (cyc == 7) begin
          chk("stall_in_ready", bus_if.in_ready, 1'b0);
          chk("stall_in_flight", sent - rcv, 2);
        end
      end else begin
        have_snap = 1'b0;
      end
      if (bus_if.out_valid && bus_if.out_ready) begin
        check_out($sformatf("stream%0d", rcv), 2 + rcv);
        rcv++;
        last_cons = cyc;
      end
      acc = bus_if.in_valid && bus_if.in_ready;
      @(posedge clk); #1;
      if (acc) sent++;
    end
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b1;
    chk("stream_count", rcv, 8);
    chk("stream_last_cycle", last_cons, 14);

`ifdef POSIT_EXTRACT_STATS_EN
    @(negedge clk);
    chk("stat_zero_cnt", stat_zero_cnt, 32'd2);
    chk("stat_inf_cnt",  stat_inf_cnt,  32'd2);
`endif

    // Reset with two items in flight.
    @(posedge clk); #1;
    bus_if.in_valid  = 1'b1;
    bus_if.in_posit  = vecs[3].p;
    bus_if.out_ready = 1'b0;
    @(posedge clk); #1;
    bus_if.in_posit  = vecs[4].p;
    @(posedge clk); #1;
    bus_if.in_valid  = 1'b0;
    @(negedge clk);
    chk("pre_rst_out_valid", bus_if.out_valid, 1'b1);
    chk("pre_rst_in_ready", bus_if.in_ready, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_rst_out_valid", bus_if.out_valid, 1'b0);
    chk("mid_rst_in_ready", bus_if.in_ready, 1'b1);
    bus_if.out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("no_stale_c%0d", c), bus_if.out_valid, 1'b0);
    end
`ifdef POSIT_EXTRACT_STATS_EN
    chk("stat_zero_cleared", stat_zero_cnt, 32'd0);
    chk("stat_inf_cleared",  stat_inf_cnt,  32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
